// File: rtl/dpe_multiplexer.sv
// dpe_multiplexer: packet-level 5:1 arbiter merging CPU and four Ethernet
// ingress streams into the single DPE input stream. Index 0 is CPU, 1..4 are
// ETH_1..ETH_4. The grant is held for a whole packet and the output stage is
// a single register that still sustains one beat per clock.
module dpe_multiplexer #(
  parameter int                 RR_EN          = 1,
  parameter int                 DATA_W         = 64,
  parameter int                 KEEP_W         = DATA_W / 8,
  parameter int                 STAGE_W        = 3,
  parameter int                 ADDR_W         = 3,
  parameter logic [ADDR_W-1:0]  DPE_ADDR_CPU   = ADDR_W'(0),
  parameter logic [ADDR_W-1:0]  DPE_ADDR_ETH_1 = ADDR_W'(1),
  parameter logic [ADDR_W-1:0]  DPE_ADDR_ETH_2 = ADDR_W'(2),
  parameter logic [ADDR_W-1:0]  DPE_ADDR_ETH_3 = ADDR_W'(3),
  parameter logic [ADDR_W-1:0]  DPE_ADDR_ETH_4 = ADDR_W'(4)
) (
  input  logic                          clk,
  input  logic                          rst,
  // ingress streams, one lane per arbitration index
  input  logic [4:0]                    from_tvalid,
  output logic [4:0]                    from_tready,
  input  logic [4:0][DATA_W-1:0]        from_tdata,
  input  logic [4:0][KEEP_W-1:0]        from_tkeep,
  input  logic [4:0]                    from_tlast,
  input  logic [4:0]                    from_tuser_bypass_all,
  input  logic [4:0][STAGE_W-1:0]       from_tuser_bypass_stage,
  input  logic [4:0][ADDR_W-1:0]        from_tuser_src,
  input  logic [4:0][ADDR_W-1:0]        from_tuser_dst,
  // merged stream into the DPE
  output logic                          to_dpe_tvalid,
  input  logic                          to_dpe_tready,
  output logic [DATA_W-1:0]             to_dpe_tdata,
  output logic [KEEP_W-1:0]             to_dpe_tkeep,
  output logic                          to_dpe_tlast,
  output logic                          to_dpe_tuser_bypass_all,
  output logic [STAGE_W-1:0]            to_dpe_tuser_bypass_stage,
  output logic [ADDR_W-1:0]             to_dpe_tuser_src,
  output logic [ADDR_W-1:0]             to_dpe_tuser_dst
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] gnt_reg, gnt_next;
  logic [2:0] last_reg, last_next;

  logic [2:0] sel_idx;
  logic       sel_valid;
  logic [2:0] cand;
  logic       load;
  logic       accept;
  logic       sel_tlast;

  // The incoming tuser_src is always replaced by the port constant.
  logic unused_src;
  assign unused_src = ^from_tuser_src;

  function automatic logic [ADDR_W-1:0] src_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    src_addr = DPE_ADDR_CPU;
      3'd1:    src_addr = DPE_ADDR_ETH_1;
      3'd2:    src_addr = DPE_ADDR_ETH_2;
      3'd3:    src_addr = DPE_ADDR_ETH_3;
      default: src_addr = DPE_ADDR_ETH_4;
    endcase
  endfunction

  // Output register can take a new beat when empty or being drained.
  assign load      = ~to_dpe_tvalid | to_dpe_tready;
  assign accept    = load & sel_valid & ~rst;
  assign sel_tlast = from_tlast[sel_idx];

  // Grant selection: held index while LOCKED, otherwise arbitrate over tvalid.
  always_comb begin
    sel_idx   = gnt_reg;
    sel_valid = 1'b0;
    cand      = last_reg;
    if (state_reg == LOCKED) begin
      sel_valid = from_tvalid[gnt_reg];
    end else if (RR_EN != 0) begin
      // Walk (last+1) mod 5 .. last and take the first valid source.
      for (int k = 0; k < 5; k++) begin
        cand = (cand == 3'd4) ? 3'd0 : cand + 3'd1;
        if (!sel_valid && from_tvalid[cand]) begin
          sel_idx   = cand;
          sel_valid = 1'b1;
        end
      end
    end else begin
      // Fixed priority: scanning downward leaves the lowest valid index.
      for (int k = 4; k >= 0; k--) begin
        if (from_tvalid[k]) begin
          sel_idx   = 3'(k);
          sel_valid = 1'b1;
        end
      end
    end
  end

  // Only the granted lane sees tready, and only when the output can load.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_ready
      assign from_tready[gi] = ~rst & load & ((state_reg == LOCKED) | sel_valid)
                             & (sel_idx == 3'(gi));
    end
  endgenerate

  // Next-state logic: lock on a non-final first beat, release on tlast.
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          last_next = sel_idx;
          if (!sel_tlast) begin
            state_next = LOCKED;
            gnt_next   = sel_idx;
          end
        end
      end
      LOCKED: begin
        if (accept && sel_tlast) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers; last=4 puts CPU first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= 3'd0;
      last_reg  <= 3'd4;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      last_reg  <= last_next;
    end
  end

  // Output register stage; fields only change when a new beat is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_dpe_tvalid             <= 1'b0;
      to_dpe_tdata              <= '0;
      to_dpe_tkeep              <= '0;
      to_dpe_tlast              <= 1'b0;
      to_dpe_tuser_bypass_all   <= 1'b0;
      to_dpe_tuser_bypass_stage <= '0;
      to_dpe_tuser_src          <= '0;
      to_dpe_tuser_dst          <= '0;
    end else if (load) begin
      to_dpe_tvalid <= accept;
      if (accept) begin
        to_dpe_tdata              <= from_tdata[sel_idx];
        to_dpe_tkeep              <= from_tkeep[sel_idx];
        to_dpe_tlast              <= sel_tlast;
        to_dpe_tuser_bypass_all   <= from_tuser_bypass_all[sel_idx];
        to_dpe_tuser_bypass_stage <= from_tuser_bypass_stage[sel_idx];
        to_dpe_tuser_src          <= src_addr(sel_idx);
        to_dpe_tuser_dst          <= from_tuser_dst[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_dpe_multiplexer.sv
// tb_dpe_multiplexer: drives two arbiters (round-robin and fixed priority)
// with random AXIS sources and random output backpressure, and checks every
// cycle against a behavioural model of the arbitration rules.
module tb_dpe_multiplexer;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int SW = 3;
  localparam int AW = 3;
  localparam int NCYC = 4600;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // per-instance stimulus and response (0 = round-robin, 1 = fixed priority)
  logic [4:0]         s_valid [2];
  logic [4:0]         s_ready [2];
  logic [4:0][DW-1:0] s_data  [2];
  logic [4:0][KW-1:0] s_keep  [2];
  logic [4:0]         s_last  [2];
  logic [4:0]         s_ball  [2];
  logic [4:0][SW-1:0] s_stage [2];
  logic [4:0][AW-1:0] s_src   [2];
  logic [4:0][AW-1:0] s_dst   [2];
  logic               o_valid [2];
  logic               o_ready [2];
  logic [DW-1:0]      o_data  [2];
  logic [KW-1:0]      o_keep  [2];
  logic               o_last  [2];
  logic               o_ball  [2];
  logic [SW-1:0]      o_stage [2];
  logic [AW-1:0]      o_src   [2];
  logic [AW-1:0]      o_dst   [2];

  dpe_multiplexer #(.RR_EN(1), .DATA_W(DW), .KEEP_W(KW), .STAGE_W(SW), .ADDR_W(AW)) u_rr (
    .clk(clk), .rst(rst),
    .from_tvalid(s_valid[0]), .from_tready(s_ready[0]), .from_tdata(s_data[0]),
    .from_tkeep(s_keep[0]), .from_tlast(s_last[0]), .from_tuser_bypass_all(s_ball[0]),
    .from_tuser_bypass_stage(s_stage[0]), .from_tuser_src(s_src[0]), .from_tuser_dst(s_dst[0]),
    .to_dpe_tvalid(o_valid[0]), .to_dpe_tready(o_ready[0]), .to_dpe_tdata(o_data[0]),
    .to_dpe_tkeep(o_keep[0]), .to_dpe_tlast(o_last[0]), .to_dpe_tuser_bypass_all(o_ball[0]),
    .to_dpe_tuser_bypass_stage(o_stage[0]), .to_dpe_tuser_src(o_src[0]), .to_dpe_tuser_dst(o_dst[0])
  );

  dpe_multiplexer #(.RR_EN(0), .DATA_W(DW), .KEEP_W(KW), .STAGE_W(SW), .ADDR_W(AW)) u_fp (
    .clk(clk), .rst(rst),
    .from_tvalid(s_valid[1]), .from_tready(s_ready[1]), .from_tdata(s_data[1]),
    .from_tkeep(s_keep[1]), .from_tlast(s_last[1]), .from_tuser_bypass_all(s_ball[1]),
    .from_tuser_bypass_stage(s_stage[1]), .from_tuser_src(s_src[1]), .from_tuser_dst(s_dst[1]),
    .to_dpe_tvalid(o_valid[1]), .to_dpe_tready(o_ready[1]), .to_dpe_tdata(o_data[1]),
    .to_dpe_tkeep(o_keep[1]), .to_dpe_tlast(o_last[1]), .to_dpe_tuser_bypass_all(o_ball[1]),
    .to_dpe_tuser_bypass_stage(o_stage[1]), .to_dpe_tuser_src(o_src[1]), .to_dpe_tuser_dst(o_dst[1])
  );

  // port address each source must be stamped with
  logic [AW-1:0] src_addr [5];

  // source bookkeeping
  int rem [2][5];
  int seq [2][5];
  logic [4:0] hs [2];

  // reference model state
  int            m_lock [2];   // -1 when no packet in flight
  int            m_last [2];
  bit            m_ov   [2];
  bit            m_zero [2];   // output fields must read as reset zeros
  bit            m_init;
  logic [DW-1:0] m_data  [2];
  logic [KW-1:0] m_keep  [2];
  logic          m_tl    [2];
  logic          m_ball  [2];
  logic [SW-1:0] m_stage [2];
  logic [AW-1:0] m_src   [2];
  logic [AW-1:0] m_dst   [2];

  int n_total = 0;
  int n_bad   = 0;
  int p_valid, p_ready;
  int w, gidx, c;
  bit load;
  logic [4:0] er;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Produce the next beat for source s of instance d (new packet when rem hits 0).
  task automatic new_beat(input int d, input int s);
    if (rem[d][s] == 0) rem[d][s] = int'($urandom_range(1, 4));
    s_data[d][s]  = DW'((d * 16 + s) << 24) | DW'(seq[d][s] & 32'h00ff_ffff);
    seq[d][s]++;
    s_last[d][s]  = (rem[d][s] == 1);
    rem[d][s]--;
    s_keep[d][s]  = KW'($urandom);
    s_ball[d][s]  = 1'($urandom);
    s_stage[d][s] = SW'($urandom);
    s_src[d][s]   = AW'($urandom);
    s_dst[d][s]   = ($urandom_range(0, 3) == 0) ? 3'd7 : AW'($urandom);
  endtask

  task automatic model_reset(input int d);
    m_lock[d] = -1;
    m_last[d] = 4;
    m_ov[d]   = 1'b0;
    m_zero[d] = 1'b1;
    m_data[d] = '0; m_keep[d] = '0; m_tl[d] = 1'b0; m_ball[d] = 1'b0;
    m_stage[d] = '0; m_src[d] = '0; m_dst[d] = '0;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) src_addr[i] = AW'(i);
    rst = 1'b1;
    m_init = 1'b0;
    p_valid = 90;
    p_ready = 100;
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = '0;
      o_ready[d] = 1'b0;
      for (int s = 0; s < 5; s++) begin
        rem[d][s] = 0;
        seq[d][s] = 0;
        new_beat(d, s);
      end
    end

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        // expected grant for this cycle from the arbitration rules
        er = '0; w = -1; gidx = -1; load = 1'b0;
        if (!rst) begin
          load = !m_ov[d] || o_ready[d];
          if (m_lock[d] >= 0) begin
            gidx = m_lock[d];
            if (s_valid[d][m_lock[d]]) w = m_lock[d];
          end else if (d == 0) begin
            for (int k = 1; k <= 5; k++) begin
              c = (m_last[d] + k) % 5;
              if (w < 0 && s_valid[d][c]) w = c;
            end
            gidx = w;
          end else begin
            for (int k = 0; k < 5; k++) if (w < 0 && s_valid[d][k]) w = k;
            gidx = w;
          end
          if (load && gidx >= 0) er[gidx] = 1'b1;
        end
        if (m_init) begin
          check_val($sformatf("u%0d tready", d), 64'(s_ready[d]), 64'(er));
          check_val($sformatf("u%0d tvalid", d), 64'(o_valid[d]), 64'(m_ov[d]));
          if (m_ov[d] || m_zero[d]) begin
            check_val($sformatf("u%0d tdata", d),  64'(o_data[d]),  64'(m_data[d]));
            check_val($sformatf("u%0d tkeep", d),  64'(o_keep[d]),  64'(m_keep[d]));
            check_val($sformatf("u%0d tlast", d),  64'(o_last[d]),  64'(m_tl[d]));
            check_val($sformatf("u%0d bypass_all", d),   64'(o_ball[d]),  64'(m_ball[d]));
            check_val($sformatf("u%0d bypass_stage", d), 64'(o_stage[d]), 64'(m_stage[d]));
            check_val($sformatf("u%0d tuser_src", d), 64'(o_src[d]), 64'(m_src[d]));
            check_val($sformatf("u%0d tuser_dst", d), 64'(o_dst[d]), 64'(m_dst[d]));
          end
        end
        hs[d] = s_valid[d] & s_ready[d];
        // advance the model to its state after the coming edge
        if (rst) begin
          model_reset(d);
        end else if (load) begin
          m_ov[d] = (w >= 0);
          if (w >= 0) begin
            m_zero[d]  = 1'b0;
            m_data[d]  = s_data[d][w];
            m_keep[d]  = s_keep[d][w];
            m_tl[d]    = s_last[d][w];
            m_ball[d]  = s_ball[d][w];
            m_stage[d] = s_stage[d][w];
            m_src[d]   = src_addr[w];
            m_dst[d]   = s_dst[d][w];
            if (m_lock[d] < 0) begin
              m_last[d] = w;
              if (!s_last[d][w]) m_lock[d] = w;
            end else if (s_last[d][w]) begin
              m_lock[d] = -1;
            end
          end
        end
      end
      if (rst) m_init = 1'b1;

      @(posedge clk);
      #1;
      // sources: advance on handshake, keep tvalid stable until accepted
      for (int d = 0; d < 2; d++) begin
        for (int s = 0; s < 5; s++) begin
          if (rst) begin
            s_valid[d][s] = 1'b0;
            rem[d][s] = 0;
            new_beat(d, s);
          end else if (hs[d][s]) begin
            new_beat(d, s);
            s_valid[d][s] = ($urandom_range(0, 99) < p_valid);
          end else if (!s_valid[d][s]) begin
            s_valid[d][s] = ($urandom_range(0, 99) < p_valid);
          end
        end
      end
      // phase control: reset windows, then varying load and backpressure
      rst = (cyc < 3) || (cyc >= 1500 && cyc < 1503) || (cyc == 3001) || (cyc == 4000);
      if (cyc < 1500)      begin p_valid = 90; p_ready = 100; end
      else if (cyc < 3000) begin p_valid = 50; p_ready = 70;  end
      else                 begin p_valid = 75; p_ready = 40;  end
      for (int d = 0; d < 2; d++) o_ready[d] = ($urandom_range(0, 99) < p_ready);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
